// File: rtl/mem_seq_pkg.sv
// Shared types for the load/store sequencer: access encoding, FSM states
// and the lane-index width helper.
package mem_seq_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_LW  = 3'b010,
        OP_LBU = 3'b011,
        OP_LHU = 3'b100,
        OP_SB  = 3'b101,
        OP_SH  = 3'b110,
        OP_SW  = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_RESP  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    // Number of byte-offset bits inside one memory word.
    function automatic int lsb_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/mem_lane_mux.sv
// Combinational lane logic: extracts and extends byte/half loads, and merges
// the store byte/half into a previously read word for read-modify-write.
module mem_lane_mux
    import mem_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int LSB_W = lsb_w(DATA_W)
) (
    input  op_e               op,
    input  logic [LSB_W-1:0]  lane,
    input  logic [DATA_W-1:0] word,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] store_data
);

    localparam int NB = DATA_W / 8;
    localparam int NH = DATA_W / 16;

    logic [7:0]        byte_lane [NB];
    logic [15:0]       half_lane [NH];
    logic [DATA_W-1:0] merged;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_byte
            localparam logic [LSB_W-1:0] IDX = LSB_W'(gi);
            assign byte_lane[gi] = word[gi*8 +: 8];
            // A half store covers two bytes; the low byte of wdata lands in the even one.
            assign merged[gi*8 +: 8] =
                (op == OP_SB && lane == IDX)                         ? wdata[7:0] :
                (op == OP_SH && lane[LSB_W-1:1] == IDX[LSB_W-1:1])   ? wdata[(gi%2)*8 +: 8] :
                                                                       word[gi*8 +: 8];
        end
        for (gi = 0; gi < NH; gi++) begin : g_half
            assign half_lane[gi] = word[gi*16 +: 16];
        end
    endgenerate

    assign byte_sel = byte_lane[lane];
    assign half_sel = half_lane[lane[LSB_W-1:1]];

    always_comb begin
        load_data = word;
        case (op)
            OP_LB:   load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {{(DATA_W-8){1'b0}}, byte_sel};
            OP_LH:   load_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {{(DATA_W-16){1'b0}}, half_sel};
            default: load_data = word;
        endcase
    end

    assign store_data = (op == OP_SW) ? wdata : merged;

endmodule

// File: rtl/mem_access_seq.sv
// Load/store sequencer: accepts one access, runs the memory handshake with a
// fixed read latency, and returns an extended load result or a merged store.
module mem_access_seq
    import mem_seq_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [2:0]        Op,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WData,
    output logic              Busy,
    output logic              Done,
    output logic              AlignErr,
    output logic [DATA_W-1:0] RData,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemWr,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData
);

    localparam int LSB_W = lsb_w(DATA_W);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    state_e            state_reg, state_next;
    op_e               op_reg, op_next;
    logic [LSB_W-1:0]  lane_reg, lane_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [DATA_W-1:0] buf_reg, buf_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;

    op_e               op_in;
    logic              is_half, is_word, misaligned;
    logic [DATA_W-1:0] mux_word, load_word, store_word;

    assign op_in = op_e'(Op);

    always_comb begin
        is_half    = (op_in == OP_LH) || (op_in == OP_LHU) || (op_in == OP_SH);
        is_word    = (op_in == OP_LW) || (op_in == OP_SW);
        misaligned = (is_half && Addr[0]) || (is_word && (Addr[LSB_W-1:0] != '0));
    end

    // On the final read cycle the lane logic works straight off the memory bus,
    // so the result or merged word is ready on the same edge the buffer loads.
    assign mux_word = (state_reg == ST_READ) ? MemRData : buf_reg;

    mem_lane_mux #(.DATA_W(DATA_W)) u_lane_mux (
        .op         (op_reg),
        .lane       (lane_reg),
        .word       (mux_word),
        .wdata      (wdata_reg),
        .load_data  (load_word),
        .store_data (store_word)
    );

    always_comb begin
        state_next     = state_reg;
        op_next        = op_reg;
        lane_next      = lane_reg;
        wdata_next     = wdata_reg;
        buf_next       = buf_reg;
        cnt_next       = cnt_reg;
        rdata_next     = rdata_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (Start) begin
                    op_next       = op_in;
                    lane_next     = Addr[LSB_W-1:0];
                    wdata_next    = WData;
                    mem_addr_next = {Addr[ADDR_W-1:LSB_W], {LSB_W{1'b0}}};
                    cnt_next      = '0;
                    if (misaligned) begin
                        state_next = ST_ERR;
                    end else if (op_in == OP_SW) begin
                        state_next     = ST_WRITE;
                        mem_wdata_next = WData;
                    end else begin
                        state_next = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (cnt_reg == CNT_LAST) begin
                    buf_next = MemRData;
                    if (op_reg == OP_SB || op_reg == OP_SH) begin
                        state_next     = ST_WRITE;
                        mem_wdata_next = store_word;
                    end else begin
                        state_next = ST_RESP;
                        rdata_next = load_word;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_WRITE: state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            ST_ERR:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_reg     <= ST_IDLE;
            op_reg        <= OP_LB;
            lane_reg      <= '0;
            wdata_reg     <= '0;
            buf_reg       <= '0;
            cnt_reg       <= '0;
            rdata_reg     <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            op_reg        <= op_next;
            lane_reg      <= lane_next;
            wdata_reg     <= wdata_next;
            buf_reg       <= buf_next;
            cnt_reg       <= cnt_next;
            rdata_reg     <= rdata_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
        end
    end

    // Handshake strobes are pure state decode so reset drops them at once.
    assign Busy     = (state_reg != ST_IDLE);
    assign Done     = (state_reg == ST_RESP);
    assign AlignErr = (state_reg == ST_ERR);
    assign MemWr    = (state_reg == ST_WRITE);
    assign RData    = rdata_reg;
    assign MemAddr  = mem_addr_reg;
    assign MemWData = mem_wdata_reg;

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: directed and random accesses on a MEM_LAT=2 and a
// MEM_LAT=1 instance, checked against an arithmetic reference model.
module tb_mem_access_seq;
    import mem_seq_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start1, start2;
    logic [2:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;

    logic          busy2, done2, aerr2, mwr2;
    logic [DW-1:0] rdata2, mwdata2, mrdata2;
    logic [AW-1:0] maddr2;
    logic          busy1, done1, aerr1, mwr1;
    logic [DW-1:0] rdata1, mwdata1, mrdata1;
    logic [AW-1:0] maddr1;

    mem_access_seq #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(2)) dut2 (
        .clk(clk), .Reset(rst_n), .Start(start2), .Op(op), .Addr(addr), .WData(wdata),
        .Busy(busy2), .Done(done2), .AlignErr(aerr2), .RData(rdata2), .MemAddr(maddr2),
        .MemWr(mwr2), .MemWData(mwdata2), .MemRData(mrdata2));

    mem_access_seq #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(1)) dut1 (
        .clk(clk), .Reset(rst_n), .Start(start1), .Op(op), .Addr(addr), .WData(wdata),
        .Busy(busy1), .Done(done1), .AlignErr(aerr1), .RData(rdata1), .MemAddr(maddr1),
        .MemWr(mwr1), .MemWData(mwdata1), .MemRData(mrdata1));

    // Memory devices: one pipeline stage for MEM_LAT=2, direct read for MEM_LAT=1.
    logic [DW-1:0] mem2 [256];
    logic [DW-1:0] mem1 [256];
    logic [DW-1:0] pipe2;
    logic          bd_we;
    logic [7:0]    bd_idx;
    logic [DW-1:0] bd_data;

    always @(posedge clk) begin
        pipe2 <= mem2[maddr2[9:2]];
        if (bd_we) begin
            mem2[bd_idx] <= bd_data;
            mem1[bd_idx] <= bd_data;
        end else begin
            if (mwr2) mem2[maddr2[9:2]] <= mwdata2;
            if (mwr1) mem1[maddr1[9:2]] <= mwdata1;
        end
    end
    assign mrdata2 = pipe2;
    assign mrdata1 = mem1[maddr1[9:2]];

    int total = 0;
    int bad = 0;
    int r_done_cyc, r_done_cnt, r_wr_cyc, r_wr_cnt, r_aerr_cyc, r_aerr_cnt, r_busy_cnt, r_ma_moved;
    logic [DW-1:0] r_wr_data;
    logic [AW-1:0] r_maddr;
    logic [DW-1:0] ref_rd1, ref_rd2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic access(input bit use1, input logic [2:0] o, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [DW-1:0] word);
        int lat, off, exp_done, exp_wr, exp_busy;
        bit is_h, is_w, is_load, mis;
        logic [DW-1:0] exp_rd, exp_mem, exp_wdata, mask, obs_rd, obs_mem;
        logic [7:0]  bv;
        logic [15:0] hv;
        logic b_busy, b_done, b_aerr, b_wr;
        logic [DW-1:0] b_wd;
        logic [AW-1:0] b_ma;

        lat     = use1 ? 1 : 2;
        off     = int'(a[1:0]);
        is_h    = (o == OP_LH) || (o == OP_LHU) || (o == OP_SH);
        is_w    = (o == OP_LW) || (o == OP_SW);
        is_load = (o <= 3'd4);
        mis     = (is_h && a[0]) || (is_w && off != 0);
        bv      = 8'((word >> (8 * off)) & 32'hFF);
        hv      = 16'((word >> (8 * (off & 2))) & 32'hFFFF);
        exp_rd    = use1 ? ref_rd1 : ref_rd2;
        exp_mem   = word;
        exp_wdata = '0;
        exp_done  = 0;
        exp_wr    = 0;
        exp_busy  = 1;
        if (!mis) begin
            case (o)
                OP_LB:  exp_rd = (bv >= 8'd128) ? (32'(bv) - 32'd256) : 32'(bv);
                OP_LBU: exp_rd = 32'(bv);
                OP_LH:  exp_rd = (hv >= 16'h8000) ? (32'(hv) - 32'h10000) : 32'(hv);
                OP_LHU: exp_rd = 32'(hv);
                OP_LW:  exp_rd = word;
                OP_SB: begin
                    mask    = 32'hFF << (8 * off);
                    exp_mem = (word & ~mask) | ((wd & 32'hFF) << (8 * off));
                end
                OP_SH: begin
                    mask    = 32'hFFFF << (8 * off);
                    exp_mem = (word & ~mask) | ((wd & 32'hFFFF) << (8 * off));
                end
                default: exp_mem = wd;
            endcase
            exp_wdata = exp_mem;
            if (is_load) begin
                exp_done = lat + 1; exp_busy = lat + 1;
            end else if (o == OP_SW) begin
                exp_done = 2; exp_wr = 1; exp_busy = 2;
            end else begin
                exp_done = lat + 2; exp_wr = lat + 1; exp_busy = lat + 2;
            end
        end

        @(posedge clk); #1;
        bd_we = 1'b1; bd_idx = a[9:2]; bd_data = word;
        @(posedge clk); #1;
        bd_we = 1'b0;
        op = o; addr = a; wdata = wd;
        if (use1) start1 = 1'b1; else start2 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start2 = 1'b0;
        op = 3'($urandom); addr = $urandom; wdata = $urandom;
        r_done_cyc = 0; r_done_cnt = 0; r_wr_cyc = 0; r_wr_cnt = 0;
        r_aerr_cyc = 0; r_aerr_cnt = 0; r_busy_cnt = 0; r_ma_moved = 0; r_wr_data = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            b_busy = use1 ? busy1 : busy2;
            b_done = use1 ? done1 : done2;
            b_aerr = use1 ? aerr1 : aerr2;
            b_wr   = use1 ? mwr1 : mwr2;
            b_wd   = use1 ? mwdata1 : mwdata2;
            b_ma   = use1 ? maddr1 : maddr2;
            if (k == 1) r_maddr = b_ma;
            else if (b_ma !== r_maddr) r_ma_moved++;
            if (b_busy) r_busy_cnt++;
            if (b_done) begin r_done_cnt++; if (r_done_cyc == 0) r_done_cyc = k; end
            if (b_aerr) begin r_aerr_cnt++; if (r_aerr_cyc == 0) r_aerr_cyc = k; end
            if (b_wr) begin
                r_wr_cnt++;
                if (r_wr_cyc == 0) begin r_wr_cyc = k; r_wr_data = b_wd; end
            end
        end
        obs_rd  = use1 ? rdata1 : rdata2;
        obs_mem = use1 ? mem1[a[9:2]] : mem2[a[9:2]];

        chk("done_cycle", r_done_cyc, exp_done);
        chk("done_count", r_done_cnt, (exp_done != 0) ? 1 : 0);
        chk("memwr_cycle", r_wr_cyc, exp_wr);
        chk("memwr_count", r_wr_cnt, (exp_wr != 0) ? 1 : 0);
        if (exp_wr != 0) chk("memwdata", r_wr_data, exp_wdata);
        chk("alignerr_cycle", r_aerr_cyc, mis ? 1 : 0);
        chk("alignerr_count", r_aerr_cnt, mis ? 1 : 0);
        chk("busy_cycles", r_busy_cnt, exp_busy);
        chk("memaddr", r_maddr, {a[AW-1:2], 2'b00});
        chk("memaddr_stable", r_ma_moved, 0);
        chk("rdata", obs_rd, exp_rd);
        chk("mem_word", obs_mem, exp_mem);
        if (use1) ref_rd1 = exp_rd; else ref_rd2 = exp_rd;
        $display("txn lat=%0d op=%0d addr=%h wdata=%h word=%h done@%0d wr@%0d aerr@%0d rdata=%h",
                 lat, o, a, wd, word, r_done_cyc, r_wr_cyc, r_aerr_cyc, obs_rd);
    endtask

    task automatic rand_access(input bit use1);
        logic [2:0]    o;
        logic [AW-1:0] a;
        o = 3'($urandom_range(0, 7));
        a = AW'($urandom_range(0, 1023));
        if ($urandom_range(0, 3) != 0) begin
            if (o == OP_LH || o == OP_LHU || o == OP_SH) a[0] = 1'b0;
            if (o == OP_LW || o == OP_SW) a[1:0] = 2'b00;
        end
        access(use1, o, a, $urandom, $urandom);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit wr_seen;
        rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0;
        op = '0; addr = '0; wdata = '0;
        bd_we = 1'b0; bd_idx = '0; bd_data = '0;
        ref_rd1 = '0; ref_rd2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy2, 1'b0);
        chk("reset_done", done2, 1'b0);
        chk("reset_alignerr", aerr2, 1'b0);
        chk("reset_memwr", mwr2, 1'b0);
        chk("reset_memaddr", maddr2, 32'h0);
        chk("reset_memwdata", mwdata2, 32'h0);
        chk("reset_rdata", rdata2, 32'h0);
        chk("reset_busy_lat1", busy1, 1'b0);
        rst_n = 1'b1;

        access(0, OP_LB, 32'h103, 32'h0, 32'h80FF_1234);
        chk("lb_value", rdata2, 32'hFFFF_FF80);
        access(0, OP_LBU, 32'h103, 32'h0, 32'h80FF_1234);
        chk("lbu_value", rdata2, 32'h0000_0080);
        access(0, OP_LH, 32'h102, 32'h0, 32'h80FF_1234);
        chk("lh_value", rdata2, 32'hFFFF_80FF);
        access(0, OP_LHU, 32'h102, 32'h0, 32'h80FF_1234);
        chk("lhu_value", rdata2, 32'h0000_80FF);
        access(0, OP_SB, 32'h101, 32'h0000_00AB, 32'h1122_3344);
        chk("sb_wdata", r_wr_data, 32'h1122_AB44);
        access(0, OP_SW, 32'h200, 32'hDEAD_BEEF, 32'h0);
        chk("sw_wdata", r_wr_data, 32'hDEAD_BEEF);
        access(0, OP_LW, 32'h102, 32'h0, 32'h1234_5678);
        chk("lw_mis_rdata", rdata2, 32'h0000_80FF);

        for (int i = 0; i < 40; i++) rand_access(0);

        // Ignored second Start, then reset in the middle of a read-modify-write.
        wr_seen = 1'b0;
        @(posedge clk); #1;
        bd_we = 1'b1; bd_idx = 8'h40; bd_data = 32'h5566_7788;
        @(posedge clk); #1;
        bd_idx = 8'h80; bd_data = 32'h0102_0304;
        @(posedge clk); #1;
        bd_we = 1'b0;
        op = OP_SH; addr = 32'h100; wdata = 32'h0000_BEEF; start2 = 1'b1;
        @(posedge clk); #1;
        op = OP_SW; addr = 32'h200; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        if (mwr2) wr_seen = 1'b1;
        chk("rob_busy_c1", busy2, 1'b1);
        @(posedge clk); #1;
        start2 = 1'b0;
        @(negedge clk);
        if (mwr2) wr_seen = 1'b1;
        chk("rob_memaddr_c2", maddr2, 32'h100);
        chk("rob_busy_c2", busy2, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("rob_rst_busy", busy2, 1'b0);
        chk("rob_rst_done", done2, 1'b0);
        chk("rob_rst_alignerr", aerr2, 1'b0);
        chk("rob_rst_memwr", mwr2, 1'b0);
        chk("rob_rst_memaddr", maddr2, 32'h0);
        chk("rob_rst_memwdata", mwdata2, 32'h0);
        chk("rob_rst_rdata", rdata2, 32'h0);
        chk("rob_rst_rdata_lat1", rdata1, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (mwr2) wr_seen = 1'b1;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (mwr2) wr_seen = 1'b1;
        end
        chk("rob_memwr_never", wr_seen, 1'b0);
        chk("rob_mem_100", mem2[8'h40], 32'h5566_7788);
        chk("rob_mem_200", mem2[8'h80], 32'h0102_0304);
        chk("rob_idle", busy2, 1'b0);
        ref_rd1 = '0;
        ref_rd2 = '0;

        access(1, OP_LW, 32'h100, $urandom, 32'hCAFE_F00D);
        chk("lat1_lw_done", r_done_cyc, 2);
        chk("lat1_lw_value", rdata1, 32'hCAFE_F00D);
        for (int i = 0; i < 12; i++) rand_access(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
